// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: rotating-priority selection of up to NUM_PORTS
// functional-unit results per cycle, broadcast on registered CDB ports.
module cdb_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int NUM_PORTS = 2,
  parameter int TAG_W     = 3,
  parameter int DATA_W    = 32
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]       req_tag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]      req_data,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_PORTS-1:0]                cdb_valid,
  output logic [NUM_PORTS-1:0][TAG_W-1:0]     cdb_tag,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]    cdb_value
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0]              cdb_valid_q, cdb_valid_d;
  logic [NUM_PORTS-1:0][TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0]  cdb_value_q, cdb_value_d;

  logic [NUM_REQ-1:0]                avail;
  logic [NUM_PORTS-1:0]              port_hit;
  logic [NUM_PORTS-1:0][PTR_W-1:0]   port_sel;
  logic [PTR_W-1:0]                  last_idx;
  logic [PTR_W:0]                    sum;
  logic [PTR_W-1:0]                  idx;

  // Each port takes the first still-unclaimed requester in rotating order, so
  // port 0 always holds the earlier unit and the last hit is the newest grant.
  always_comb begin
    avail    = req_valid & {NUM_REQ{reset_n & ~flush}};
    grant    = '0;
    port_hit = '0;
    port_sel = '0;
    last_idx = rr_ptr_q;
    sum      = '0;
    idx      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
        if (sum >= (PTR_W+1)'(NUM_REQ)) begin
          sum = sum - (PTR_W+1)'(NUM_REQ);
        end
        idx = sum[PTR_W-1:0];
        if (!port_hit[p] && avail[idx]) begin
          port_hit[p] = 1'b1;
          port_sel[p] = idx;
          avail[idx]  = 1'b0;
          grant[idx]  = 1'b1;
          last_idx    = idx;
        end
      end
    end
  end

  always_comb begin
    cdb_valid_d = port_hit;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_hit[p]) begin
        cdb_tag_d[p]   = req_tag[port_sel[p]];
        cdb_value_d[p] = req_data[port_sel[p]];
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (|port_hit) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_REQ-1)) ? '0 : last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= '0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a driver queues expected broadcasts, a
// negedge monitor pops and compares whenever the CDB shows a valid port.
module tb_cdb_arbiter;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              flush;
  logic [4:0]        req_valid;
  logic [4:0][2:0]   req_tag;
  logic [4:0][31:0]  req_data;
  logic [4:0]        grant;
  logic [1:0]        cdb_valid;
  logic [1:0][2:0]   cdb_tag;
  logic [1:0][31:0]  cdb_value;

  typedef struct {
    logic [1:0]  v;
    logic [2:0]  t0, t1;
    logic [31:0] d0, d1;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [2:0]  held_t[2];
  logic [31:0] held_d[2];

  cdb_arbiter #(.NUM_REQ(5), .NUM_PORTS(2)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .grant(grant), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of requests and queue the broadcast the next edge must produce.
  task automatic drive(input logic [4:0] v, input logic f, input logic [4:0] eg,
                       input int p0, input int p1);
    exp_t e;
    @(negedge clk);
    req_valid = v;
    flush     = f;
    #1;
    chk("grant", 64'(grant), 64'(eg));
    if (p0 >= 0) begin
      e.v  = (p1 >= 0) ? 2'b11 : 2'b01;
      e.t0 = req_tag[p0];
      e.d0 = req_data[p0];
      e.t1 = (p1 >= 0) ? req_tag[p1] : 3'd0;
      e.d1 = (p1 >= 0) ? req_data[p1] : 32'd0;
      expq.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    held_t[0] = '0; held_t[1] = '0;
    held_d[0] = '0; held_d[1] = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held_t[0] = '0; held_t[1] = '0;
        held_d[0] = '0; held_d[1] = '0;
      end else if (cdb_valid != 2'b00) begin
        if (expq.size() == 0) begin
          chk("unexpected_cdb_valid", 64'(cdb_valid), 64'd0);
        end else begin
          e = expq.pop_front();
          chk("cdb_valid", 64'(cdb_valid), 64'(e.v));
          if (e.v[0]) begin
            chk("port0_tag", 64'(cdb_tag[0]), 64'(e.t0));
            chk("port0_value", 64'(cdb_value[0]), 64'(e.d0));
            held_t[0] = e.t0; held_d[0] = e.d0;
          end
          if (e.v[1]) begin
            chk("port1_tag", 64'(cdb_tag[1]), 64'(e.t1));
            chk("port1_value", 64'(cdb_value[1]), 64'(e.d1));
            held_t[1] = e.t1; held_d[1] = e.d1;
          end else begin
            chk("port1_hold_tag", 64'(cdb_tag[1]), 64'(held_t[1]));
          end
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          chk("hold_tag", 64'(cdb_tag[p]), 64'(held_t[p]));
          chk("hold_value", 64'(cdb_value[p]), 64'(held_d[p]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 5'b11111;
    for (int u = 0; u < 5; u++) begin
      req_tag[u]  = 3'(u);
      req_data[u] = 32'hA000_0000 + 32'(u);
    end
    #2;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    @(posedge clk); #1;
    chk("rst_cdb_valid_after_edge", 64'(cdb_valid), 64'd0);
    @(negedge clk);
    req_valid = '0;
    reset_n   = 1'b1;

    // All five requesting from reset; units drop once granted, unit 0 returns.
    drive(5'b11111, 1'b0, 5'b00011, 0, 1);
    drive(5'b11100, 1'b0, 5'b01100, 2, 3);
    req_tag[0]  = 3'd7;
    req_data[0] = 32'hB000_0000;
    drive(5'b10001, 1'b0, 5'b10001, 4, 0);
    drive(5'b00000, 1'b0, 5'b00000, -1, -1);

    // Single request, rr_ptr=1 -> unit 2 on port 0, rr_ptr becomes 3.
    req_tag[2]  = 3'd5;
    req_data[2] = 32'hDEAD_BEEF;
    drive(5'b00100, 1'b0, 5'b00100, 2, -1);
    drive(5'b00000, 1'b0, 5'b00000, -1, -1);
    drive(5'b01001, 1'b0, 5'b01001, 3, 0);

    // Walk rr_ptr to 4, then the wrap scan picks unit 4 before unit 0.
    drive(5'b01000, 1'b0, 5'b01000, 3, -1);
    drive(5'b10001, 1'b0, 5'b10001, 4, 0);

    // Flush squashes grants for two cycles; rr_ptr stays 1.
    drive(5'b01010, 1'b1, 5'b00000, -1, -1);
    drive(5'b01010, 1'b1, 5'b00000, -1, -1);
    drive(5'b01010, 1'b0, 5'b01010, 1, 3);

    // Three requesters from rr_ptr=4: only two win, unit 2 follows next cycle.
    drive(5'b00111, 1'b0, 5'b00011, 0, 1);
    drive(5'b00100, 1'b0, 5'b00100, 2, -1);

    // Duplicate tags broadcast unchanged; last grant is unit 4 so rr_ptr -> 0.
    req_tag[3]  = 3'd6;
    req_tag[4]  = 3'd6;
    req_data[3] = 32'hC000_0003;
    req_data[4] = 32'hC000_0004;
    drive(5'b11000, 1'b0, 5'b11000, 3, 4);

    // Async reset between edges while both ports are valid.
    drive(5'b00110, 1'b0, 5'b00110, 1, 2);
    @(negedge clk);
    req_valid = 5'b11111;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("async_rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("async_rst_grant", 64'(grant), 64'd0);
    @(negedge clk);
    @(negedge clk);
    req_valid = '0;
    reset_n   = 1'b1;

    // rr_ptr back at 0: unit 0 ahead of unit 4.
    drive(5'b10001, 1'b0, 5'b10001, 0, 4);
    drive(5'b00000, 1'b0, 5'b00000, -1, -1);
    drive(5'b00000, 1'b0, 5'b00000, -1, -1);
    chk("pending_broadcasts", 64'(expq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
